// File: rtl/regfile_wb_scoreboard_if.sv
// rtl/regfile_wb_scoreboard_if.sv - read, writeback, issue and stall signals of the GPR write end
interface regfile_wb_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] raddr1_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic              re1_i;
    logic              re2_i;
    logic [DATA_W-1:0] rdata1_o;
    logic [DATA_W-1:0] rdata2_o;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_waddr_i;
    logic [DATA_W-1:0] wb_wdata_i;
    logic              wb_late_i;
    logic              issue_valid_i;
    logic [ADDR_W-1:0] issue_addr_i;
    logic              issue_ready_o;
    logic              flush_i;
    logic              stall_o;
    logic              err_o;

    modport slave (
        input  raddr1_i, raddr2_i, re1_i, re2_i,
        output rdata1_o, rdata2_o,
        input  wb_we_i, wb_waddr_i, wb_wdata_i, wb_late_i,
        input  issue_valid_i, issue_addr_i,
        output issue_ready_o,
        input  flush_i,
        output stall_o, err_o
    );

    modport master (
        output raddr1_i, raddr2_i, re1_i, re2_i,
        input  rdata1_o, rdata2_o,
        output wb_we_i, wb_waddr_i, wb_wdata_i, wb_late_i,
        output issue_valid_i, issue_addr_i,
        input  issue_ready_o,
        output flush_i,
        input  stall_o, err_o
    );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// rtl/regfile_wb_scoreboard.sv - 2R1W register file with write-through and pending-write scoreboard
module regfile_wb_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    regfile_wb_scoreboard_if.slave bus
);
    localparam int               NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic              err_q;
    logic              err_d;

    logic [CNT_W-1:0]  wcnt, icnt, c1, c2;
    logic              dec_hit, inc_hit, bad_retire, ready_raw;
    logic              pend1, pend2;

    assign wcnt = cnt_q[bus.wb_waddr_i];
    assign icnt = cnt_q[bus.issue_addr_i];
    assign c1   = cnt_q[bus.raddr1_i];
    assign c2   = cnt_q[bus.raddr2_i];

    // A late retire only counts down a register that actually has a result outstanding.
    assign dec_hit    = bus.wb_we_i && bus.wb_late_i && (bus.wb_waddr_i != '0) && (wcnt != '0);
    assign bad_retire = bus.wb_we_i && bus.wb_late_i && (bus.wb_waddr_i != '0) && (wcnt == '0)
                        && !bus.flush_i;

    assign ready_raw = (bus.issue_addr_i == '0) || (icnt != CNT_MAX)
                       || (dec_hit && (bus.wb_waddr_i == bus.issue_addr_i));
    assign bus.issue_ready_o = !rst_i && ready_raw;
    assign inc_hit = bus.issue_valid_i && bus.issue_ready_o && (bus.issue_addr_i != '0);

    // The last outstanding write retiring this cycle is supplied by write-through, so no stall.
    assign pend1 = (bus.raddr1_i != '0) && (c1 != '0)
                   && !(dec_hit && (bus.wb_waddr_i == bus.raddr1_i) && (c1 == CNT_ONE));
    assign pend2 = (bus.raddr2_i != '0) && (c2 != '0)
                   && !(dec_hit && (bus.wb_waddr_i == bus.raddr2_i) && (c2 == CNT_ONE));

    assign bus.stall_o = !rst_i && ((bus.re1_i && pend1) || (bus.re2_i && pend2)
                                    || (bus.issue_valid_i && !ready_raw));
    assign bus.err_o   = err_q;

    always_comb begin
        bus.rdata1_o = '0;
        if (!rst_i && (bus.raddr1_i != '0)) begin
            if (bus.wb_we_i && (bus.wb_waddr_i == bus.raddr1_i)) begin
                bus.rdata1_o = bus.wb_wdata_i;
            end else begin
                bus.rdata1_o = regs_q[bus.raddr1_i];
            end
        end
    end

    always_comb begin
        bus.rdata2_o = '0;
        if (!rst_i && (bus.raddr2_i != '0)) begin
            if (bus.wb_we_i && (bus.wb_waddr_i == bus.raddr2_i)) begin
                bus.rdata2_o = bus.wb_wdata_i;
            end else begin
                bus.rdata2_o = regs_q[bus.raddr2_i];
            end
        end
    end

    // Issue and retire to the same register in one cycle cancel out.
    always_comb begin
        for (int a = 0; a < NREG; a++) begin
            cnt_d[a] = cnt_q[a];
            if (bus.flush_i) begin
                cnt_d[a] = '0;
            end else if (inc_hit && (bus.issue_addr_i == ADDR_W'(a))
                         && !(dec_hit && (bus.wb_waddr_i == ADDR_W'(a)))) begin
                cnt_d[a] = cnt_q[a] + CNT_ONE;
            end else if (dec_hit && (bus.wb_waddr_i == ADDR_W'(a))
                         && !(inc_hit && (bus.issue_addr_i == ADDR_W'(a)))) begin
                cnt_d[a] = cnt_q[a] - CNT_ONE;
            end
        end
    end

    assign err_d = err_q || bad_retire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wb_we_i && (bus.wb_waddr_i != '0)) begin
            regs_q[bus.wb_waddr_i] <= bus.wb_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// tb/tb_regfile_wb_scoreboard.sv - directed and randomized self-checking bench for regfile_wb_scoreboard
module tb_regfile_wb_scoreboard;
    localparam int CNT_MAX = 3;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_err;

    regfile_wb_scoreboard_if bus ();

    regfile_wb_scoreboard dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (rst || a == 0) return '0;
        if (bus.wb_we_i && bus.wb_waddr_i == a) return bus.wb_wdata_i;
        return m_regs[a];
    endfunction

    function automatic bit m_retiring(input logic [4:0] a);
        return bus.wb_we_i && bus.wb_late_i && bus.wb_waddr_i == a && a != 0 && m_cnt[a] > 0;
    endfunction

    // Outstanding writes left once this cycle's retirement is accounted for.
    function automatic bit m_pending(input logic [4:0] a);
        int left;
        if (a == 0) return 1'b0;
        left = m_cnt[a] - (m_retiring(a) ? 1 : 0);
        return left > 0;
    endfunction

    function automatic bit m_ready();
        int room;
        if (rst) return 1'b0;
        if (bus.issue_addr_i == 0) return 1'b1;
        room = CNT_MAX - m_cnt[bus.issue_addr_i] + (m_retiring(bus.issue_addr_i) ? 1 : 0);
        return room > 0;
    endfunction

    function automatic bit m_operand_stall();
        return (bus.re1_i && m_pending(bus.raddr1_i)) || (bus.re2_i && m_pending(bus.raddr2_i));
    endfunction

    function automatic bit m_stall();
        if (rst) return 1'b0;
        return m_operand_stall() || (bus.issue_valid_i && !m_ready());
    endfunction

    function automatic void m_update();
        bit rdy;
        if (rst) begin
            m_clear();
            return;
        end
        rdy = m_ready();
        if (bus.wb_we_i && bus.wb_waddr_i != 0) m_regs[bus.wb_waddr_i] = bus.wb_wdata_i;
        if (bus.flush_i) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
            if (bus.wb_we_i && bus.wb_late_i && bus.wb_waddr_i != 0) begin
                if (m_cnt[bus.wb_waddr_i] == 0) m_err = 1'b1;
                else m_cnt[bus.wb_waddr_i]--;
            end
            if (bus.issue_valid_i && rdy && bus.issue_addr_i != 0) m_cnt[bus.issue_addr_i]++;
        end
    endfunction

    task automatic check_all();
        chk("rdata1", bus.rdata1_o, m_read(bus.raddr1_i));
        chk("rdata2", bus.rdata2_o, m_read(bus.raddr2_i));
        chk("stall", 32'(bus.stall_o), 32'(m_stall()));
        chk("issue_ready", 32'(bus.issue_ready_o), 32'(m_ready()));
        chk("err", 32'(bus.err_o), 32'(m_err));
    endtask

    task automatic idle();
        bus.raddr1_i = '0; bus.raddr2_i = '0; bus.re1_i = 1'b0; bus.re2_i = 1'b0;
        bus.wb_we_i = 1'b0; bus.wb_waddr_i = '0; bus.wb_wdata_i = '0; bus.wb_late_i = 1'b0;
        bus.issue_valid_i = 1'b0; bus.issue_addr_i = '0; bus.flush_i = 1'b0;
    endtask

    task automatic to_check();
        @(negedge clk);
        check_all();
    endtask

    task automatic to_edge();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic tick();
        to_check();
        to_edge();
    endtask

    task automatic issue(input logic [4:0] a);
        idle();
        bus.issue_valid_i = 1'b1;
        bus.issue_addr_i  = a;
    endtask

    task automatic late_wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we_i = 1'b1; bus.wb_late_i = 1'b1; bus.wb_waddr_i = a; bus.wb_wdata_i = d;
    endtask

    // Reset is raised between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        bus.raddr1_i = 5'd5; bus.re1_i = 1'b1; bus.raddr2_i = 5'd3; bus.re2_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rdata1", bus.rdata1_o, 32'h0);
        chk("async_rst_rdata2", bus.rdata2_o, 32'h0);
        chk("async_rst_stall", 32'(bus.stall_o), 32'h0);
        chk("async_rst_ready", 32'(bus.issue_ready_o), 32'h0);
        chk("async_rst_err", 32'(bus.err_o), 32'h0);
        m_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        bus.raddr1_i = 5'd5; bus.re1_i = 1'b1; bus.raddr2_i = 5'd3; bus.re2_i = 1'b1;
        to_check();
        chk("post_rst_r5", bus.rdata1_o, 32'h0);
        chk("post_rst_stall", 32'(bus.stall_o), 32'h0);
        to_edge();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        m_clear();
        bus.raddr1_i = 5'd5;
        #2;
        chk("reset_rdata1", bus.rdata1_o, 32'h0);
        chk("reset_ready", 32'(bus.issue_ready_o), 32'h0);
        chk("reset_err", 32'(bus.err_o), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        idle();
        bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd5; bus.wb_wdata_i = 32'hDEADBEEF; bus.raddr1_i = 5'd5;
        to_check();
        chk("wt_r5", bus.rdata1_o, 32'hDEADBEEF);
        to_edge();
        idle(); bus.raddr2_i = 5'd5;
        tick();

        idle();
        bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd0; bus.wb_wdata_i = 32'h1234;
        to_check();
        chk("r0_same_cycle", bus.rdata1_o, 32'h0);
        to_edge();
        idle();
        to_check();
        chk("r0_after", bus.rdata1_o, 32'h0);
        to_edge();

        issue(5'd8);
        to_check();
        chk("issue_r8_ready", 32'(bus.issue_ready_o), 32'h1);
        to_edge();
        idle(); bus.re1_i = 1'b1; bus.raddr1_i = 5'd8;
        to_check();
        chk("r8_stall", 32'(bus.stall_o), 32'h1);
        to_edge();
        idle(); bus.re1_i = 1'b1; bus.raddr1_i = 5'd8; late_wb(5'd8, 32'h55);
        to_check();
        chk("r8_retire_nostall", 32'(bus.stall_o), 32'h0);
        chk("r8_retire_data", bus.rdata1_o, 32'h55);
        to_edge();
        idle(); bus.re1_i = 1'b1; bus.raddr1_i = 5'd8;
        to_check();
        chk("r8_after", 32'(bus.stall_o), 32'h0);
        to_edge();

        for (int i = 0; i < 3; i++) begin
            issue(5'd3);
            tick();
        end
        issue(5'd3);
        to_check();
        chk("r3_full_ready", 32'(bus.issue_ready_o), 32'h0);
        chk("r3_full_stall", 32'(bus.stall_o), 32'h1);
        to_edge();
        issue(5'd3); late_wb(5'd3, 32'h33);
        to_check();
        chk("r3_swap_ready", 32'(bus.issue_ready_o), 32'h1);
        chk("r3_swap_stall", 32'(bus.stall_o), 32'h0);
        to_edge();
        issue(5'd3);
        to_check();
        chk("r3_still_full", 32'(bus.issue_ready_o), 32'h0);
        to_edge();
        idle(); bus.re1_i = 1'b1; bus.raddr1_i = 5'd3;
        to_check();
        chk("r3_pending", 32'(bus.stall_o), 32'h1);
        to_edge();

        issue(5'd9);
        tick();
        issue(5'd10);
        tick();
        idle(); bus.flush_i = 1'b1;
        tick();
        idle(); bus.re1_i = 1'b1; bus.raddr1_i = 5'd9; bus.re2_i = 1'b1; bus.raddr2_i = 5'd10;
        to_check();
        chk("flush_nostall", 32'(bus.stall_o), 32'h0);
        chk("flush_err0", 32'(bus.err_o), 32'h0);
        to_edge();
        idle(); late_wb(5'd9, 32'h77);
        tick();
        idle();
        to_check();
        chk("err_set", 32'(bus.err_o), 32'h1);
        to_edge();
        repeat (3) tick();
        to_check();
        chk("err_sticky", 32'(bus.err_o), 32'h1);
        to_edge();

        async_reset();

        for (int n = 0; n < 400; n++) begin
            idle();
            bus.raddr1_i   = 5'($urandom_range(0, 7));
            bus.raddr2_i   = 5'($urandom_range(0, 7));
            bus.re1_i      = 1'($urandom_range(0, 1));
            bus.re2_i      = 1'($urandom_range(0, 1));
            bus.wb_we_i    = 1'($urandom_range(0, 1));
            bus.wb_waddr_i = 5'($urandom_range(0, 7));
            bus.wb_wdata_i = $urandom;
            if (bus.wb_we_i) begin
                if (m_cnt[bus.wb_waddr_i] > 0) bus.wb_late_i = 1'($urandom_range(0, 1));
                else bus.wb_late_i = ($urandom_range(0, 60) == 0);
            end
            bus.issue_valid_i = ($urandom_range(0, 2) == 0);
            bus.issue_addr_i  = 5'($urandom_range(0, 7));
            bus.flush_i       = ($urandom_range(0, 40) == 0);
            if (m_operand_stall()) bus.issue_valid_i = 1'b0;
            tick();
        end

        async_reset();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
